// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN sequencer pushing operands onto a small stack and
// folding the top two entries through an external combinational ALU.
module rpn_stack_ctrl #(
    parameter int C_WIDTH = 16,
    parameter int C_DEPTH = 4,
    localparam int C_SP_W = $clog2(C_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               exec,
    input  logic               clear,
    input  logic [C_WIDTH-1:0] value,
    input  logic [1:0]         opcode,
    output logic [C_WIDTH-1:0] alu_a,
    output logic [C_WIDTH-1:0] alu_b,
    output logic [1:0]         alu_op,
    input  logic [C_WIDTH-1:0] alu_result,
    input  logic [3:0]         alu_status,
    output logic [C_WIDTH-1:0] display,
    output logic [3:0]         flags,
    output logic [C_SP_W-1:0]  depth,
    output logic               busy,
    output logic               error
);
    localparam int IDX_W = $clog2(C_DEPTH);
    localparam logic [C_SP_W-1:0] SP_MAX = C_SP_W'(C_DEPTH);
    localparam logic [4*C_WIDTH-1:0] ERR_FULL = {C_WIDTH{4'hE}};
    localparam logic [C_WIDTH-1:0] ERR_PAT = ERR_FULL[C_WIDTH-1:0];

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ERROR} state_t;

    state_t state, state_nx;
    logic [C_SP_W-1:0] sp;
    logic [C_WIDTH-1:0] stack [C_DEPTH];
    logic [IDX_W-1:0] top_i, sec_i, sp_i;
    logic can_pop, full;

    assign top_i = IDX_W'(sp - C_SP_W'(1));
    assign sec_i = IDX_W'(sp - C_SP_W'(2));
    assign sp_i = IDX_W'(sp);
    assign can_pop = sp >= C_SP_W'(2);
    assign full = sp == SP_MAX;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nx;
    end

    // exec outranks push, so a coincident push is simply dropped
    always_comb begin
        state_nx = state;
        if (clear) state_nx = ST_IDLE;
        else if (state == ST_IDLE) begin
            if (exec) state_nx = can_pop ? ST_EXEC : ST_ERROR;
            else if (push) state_nx = full ? ST_ERROR : ST_IDLE;
        end
        else if (state == ST_EXEC) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
            flags <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            for (int i = 0; i < C_DEPTH; i++) stack[i] <= '0;
        end
        else if (clear) begin
            sp <= '0;
            flags <= '0;
        end
        else if (state == ST_IDLE) begin
            if (exec) begin
                if (can_pop) begin
                    alu_a <= stack[sec_i];
                    alu_b <= stack[top_i];
                    alu_op <= opcode;
                end
            end
            else if (push && !full) begin
                stack[sp_i] <= value;
                sp <= sp + C_SP_W'(1);
            end
        end
        else if (state == ST_EXEC) begin
            stack[sec_i] <= alu_result;
            sp <= sp - C_SP_W'(1);
            flags <= alu_status;
        end
    end

    always_comb begin
        display = state == ST_ERROR ? ERR_PAT : sp == '0 ? value : stack[top_i];
        busy = state == ST_EXEC;
        error = state == ST_ERROR;
        depth = sp;
    end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb_rpn_stack_ctrl: directed checks of rpn_stack_ctrl with an adder as the ALU.
module tb_rpn_stack_ctrl;
    logic clk = 0, rst_n = 0, push = 0, exec = 0, clear = 0;
    logic [15:0] value = 0, alu_a, alu_b, alu_result, display;
    logic [1:0] opcode = 0, alu_op;
    logic [3:0] alu_status, flags;
    logic [2:0] depth;
    logic busy, error;
    int n_run = 0, n_fail = 0;

    rpn_stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .push(push), .exec(exec), .clear(clear),
        .value(value), .opcode(opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .alu_status(alu_status),
        .display(display), .flags(flags), .depth(depth), .busy(busy),
        .error(error)
    );

    assign alu_result = alu_a + alu_b;
    assign alu_status = 4'b0001;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [15:0] v);
        value = v;
        push = 1;
        tick();
        push = 0;
    endtask

    task automatic do_exec(input logic [1:0] op);
        opcode = op;
        exec = 1;
        tick();
        exec = 0;
    endtask

    task automatic do_clear;
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        value = 16'h1234;
        tick();
        tick();
        rst_n = 1;
        check("rst_depth", depth, 0);
        check("rst_display", display, 16'h1234);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_alu_a", alu_a, 0);

        do_push(16'h0005);
        do_push(16'h0003);
        check("t1_depth", depth, 2);
        check("t1_display", display, 16'h0003);
        check("t1_flags", flags, 0);

        do_exec(2'd1);
        check("t2_busy", busy, 1);
        check("t2_alu_a", alu_a, 5);
        check("t2_alu_b", alu_b, 3);
        check("t2_alu_op", alu_op, 1);
        check("t2_depth_mid", depth, 2);
        tick();
        check("t2_busy_low", busy, 0);
        check("t2_display", display, 16'h0008);
        check("t2_depth", depth, 1);
        check("t2_flags", flags, 4'b0001);

        do_clear();
        for (int i = 1; i <= 4; i++) do_push(16'(i));
        check("t3_full_depth", depth, 4);
        check("t3_full_display", display, 4);
        do_push(16'h0009);
        check("t3_error", error, 1);
        check("t3_err_display", display, 16'hEEEE);
        check("t3_err_depth", depth, 4);
        do_push(16'h0009);
        check("t3_err_hold", depth, 4);
        value = 16'hABCD;
        do_clear();
        check("t3_clr_error", error, 0);
        check("t3_clr_depth", depth, 0);
        check("t3_clr_display", display, 16'hABCD);

        do_push(16'h0007);
        do_exec(2'd0);
        check("t4_error", error, 1);
        check("t4_depth", depth, 1);
        do_push(16'h0008);
        do_exec(2'd0);
        check("t4_hold_depth", depth, 1);
        check("t4_hold_error", error, 1);
        do_clear();
        check("t4_clr_error", error, 0);
        check("t4_clr_depth", depth, 0);

        do_push(16'd10);
        do_push(16'd20);
        value = 16'd99;
        push = 1;
        do_exec(2'd2);
        push = 0;
        check("t5_busy", busy, 1);
        check("t5_alu_op", alu_op, 2);
        tick();
        check("t5_depth", depth, 1);
        check("t5_display", display, 16'd30);
        check("t5_flags", flags, 1);

        do_push(16'd1);
        do_exec(2'd3);
        check("t6_busy", busy, 1);
        do_clear();
        check("t6_depth", depth, 0);
        check("t6_flags", flags, 0);
        check("t6_busy_low", busy, 0);
        tick();
        check("t6_no_write", depth, 0);

        do_push(16'h0005);
        do_push(16'h0006);
        do_exec(2'd1);
        check("t7_busy", busy, 1);
        rst_n = 0;
        tick();
        check("t7_depth", depth, 0);
        check("t7_busy", busy, 0);
        check("t7_error", error, 0);
        check("t7_flags", flags, 0);
        check("t7_alu_a", alu_a, 0);
        check("t7_alu_b", alu_b, 0);
        check("t7_alu_op", alu_op, 0);
        rst_n = 1;
        tick();
        check("t7_post_depth", depth, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
